// File: rtl/scaler_dda.sv
// Streaming monochrome downscaler with DDA (Bresenham) accumulators for arbitrary rational ratios.
// Define SCALER_OR_FILTER_EN to OR each horizontal span together instead of nearest-neighbour.
module scaler_dda #(
  parameter int unsigned INPUT_WIDTH   = 800,
  parameter int unsigned INPUT_HEIGHT  = 600,
  parameter int unsigned OUTPUT_WIDTH  = 512,
  parameter int unsigned OUTPUT_HEIGHT = 342
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable_in,
  input  logic                             mono_pixel_in,
  input  logic [$clog2(INPUT_WIDTH)-1:0]   input_x,
  input  logic [$clog2(INPUT_HEIGHT)-1:0]  input_y,
  output logic                             scaled_mono_pixel,
  output logic                             scaled_write_enable,
  output logic [$clog2(OUTPUT_WIDTH)-1:0]  scaled_write_x,
  output logic [$clog2(OUTPUT_HEIGHT)-1:0] scaled_write_y,
  output logic                             scaled_frame_start,
  output logic                             sync_error
);
  localparam int unsigned XiW    = $clog2(INPUT_WIDTH);
  localparam int unsigned YiW    = $clog2(INPUT_HEIGHT);
  localparam int unsigned XoW    = $clog2(OUTPUT_WIDTH);
  localparam int unsigned YoW    = $clog2(OUTPUT_HEIGHT);
  localparam int unsigned MaxDim = (INPUT_WIDTH > INPUT_HEIGHT) ? INPUT_WIDTH : INPUT_HEIGHT;
  localparam int unsigned AccW   = $clog2(MaxDim) + 1;

  localparam logic [AccW-1:0] InW  = AccW'(INPUT_WIDTH);
  localparam logic [AccW-1:0] InH  = AccW'(INPUT_HEIGHT);
  localparam logic [AccW-1:0] OutW = AccW'(OUTPUT_WIDTH);
  localparam logic [AccW-1:0] OutH = AccW'(OUTPUT_HEIGHT);
  localparam logic [XoW-1:0]  MaxX = XoW'(OUTPUT_WIDTH - 1);
  localparam logic [YoW-1:0]  MaxY = YoW'(OUTPUT_HEIGHT - 1);

  if (OUTPUT_WIDTH > INPUT_WIDTH) begin : g_bad_width
    $error("scaler_dda: OUTPUT_WIDTH must not exceed INPUT_WIDTH");
  end
  if (OUTPUT_HEIGHT > INPUT_HEIGHT) begin : g_bad_height
    $error("scaler_dda: OUTPUT_HEIGHT must not exceed INPUT_HEIGHT");
  end

  typedef enum logic {StWaitSof, StActive} state_e;

  state_e          state_q, state_d;
  logic [XiW-1:0]  ex_q, ex_d;
  logic [YiW-1:0]  ey_q, ey_d;
  logic [AccW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [XoW-1:0]  out_x_q, out_x_d, wx_q, wx_d;
  logic [YoW-1:0]  out_y_q, out_y_d, wy_q, wy_d;
  logic            we_q, we_d, fs_q, fs_d, pix_q, pix_d, sync_error_q, sync_error_d;

  logic            is_origin, match, sof, err, accept, last_px, last_ln, px_sel, ln_sel;
  logic [AccW-1:0] cur_acc_x, cur_acc_y, sum_x, sum_y;
  logic [XoW-1:0]  cur_out_x;
  logic [YoW-1:0]  cur_out_y;

  assign is_origin = (input_x == '0) && (input_y == '0);
  assign match     = (input_x == ex_q) && (input_y == ey_q);
  // A (0,0) pixel that breaks raster order still restarts the frame in the same cycle.
  assign sof       = enable_in && is_origin && ((state_q == StWaitSof) || !match);
  assign err       = enable_in && (state_q == StActive) && !match;
  assign accept    = sof || (enable_in && (state_q == StActive) && match);
  assign last_px   = (input_x == XiW'(INPUT_WIDTH - 1));
  assign last_ln   = (input_y == YiW'(INPUT_HEIGHT - 1));
  assign cur_acc_x = (input_x == '0) ? '0 : acc_x_q;
  assign cur_out_x = (input_x == '0) ? '0 : out_x_q;
  assign cur_acc_y = sof ? '0 : acc_y_q;
  assign cur_out_y = sof ? '0 : out_y_q;
  assign px_sel    = (cur_acc_x < OutW);
  assign ln_sel    = (cur_acc_y < OutH);
  assign sum_x     = cur_acc_x + OutW;
  assign sum_y     = cur_acc_y + OutH;

`ifdef SCALER_OR_FILTER_EN
  logic           span_open_q, span_open_d, span_val_q, span_val_d;
  logic [XoW-1:0] span_x_q, span_x_d, pend_x_q, pend_x_d;
  logic [YoW-1:0] span_y_q, span_y_d, pend_y_q, pend_y_d;
  logic           pend_q, pend_d, pend_val_q, pend_val_d;
  logic           open_eff, new_val;
  logic [XoW-1:0] new_x;

  assign open_eff = span_open_q && !sof;
  assign new_val  = px_sel ? mono_pixel_in : (span_val_q | mono_pixel_in);
  assign new_x    = px_sel ? cur_out_x : span_x_q;
`endif

  always_comb begin
    state_d      = state_q;
    ex_d         = ex_q;
    ey_d         = ey_q;
    acc_x_d      = acc_x_q;
    acc_y_d      = acc_y_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    sync_error_d = sync_error_q;
    we_d         = 1'b0;
    fs_d         = 1'b0;
    pix_d        = pix_q;
    wx_d         = wx_q;
    wy_d         = wy_q;
`ifdef SCALER_OR_FILTER_EN
    span_open_d  = span_open_q;
    span_val_d   = span_val_q;
    span_x_d     = span_x_q;
    span_y_d     = span_y_q;
    pend_d       = 1'b0;
    pend_val_d   = pend_val_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    // Deferred write when the line's last pixel closed two spans at once.
    if (pend_q) begin
      we_d  = 1'b1;
      pix_d = pend_val_q;
      wx_d  = pend_x_q;
      wy_d  = pend_y_q;
      fs_d  = (pend_x_q == '0) && (pend_y_q == '0);
    end
`endif

    if (err) begin
      sync_error_d = 1'b1;
      state_d      = StWaitSof;
`ifdef SCALER_OR_FILTER_EN
      span_open_d  = 1'b0;
`endif
    end else if (sof) begin
      sync_error_d = 1'b0;
    end

    if (accept) begin
      acc_x_d = (sum_x >= InW) ? sum_x - InW : sum_x;
      out_x_d = (px_sel && (cur_out_x != MaxX)) ? cur_out_x + 1'b1 : cur_out_x;
      acc_y_d = cur_acc_y;
      out_y_d = cur_out_y;
      if (last_px) begin
        ex_d    = '0;
        acc_y_d = (sum_y >= InH) ? sum_y - InH : sum_y;
        if (ln_sel && (cur_out_y != MaxY)) out_y_d = cur_out_y + 1'b1;
        if (last_ln) begin
          state_d = StWaitSof;
          ey_d    = '0;
        end else begin
          state_d = StActive;
          ey_d    = input_y + 1'b1;
        end
      end else begin
        state_d = StActive;
        ex_d    = input_x + 1'b1;
        ey_d    = input_y;
      end

`ifdef SCALER_OR_FILTER_EN
      if (ln_sel) begin
        if (px_sel && open_eff) begin
          we_d  = 1'b1;
          pix_d = span_val_q;
          wx_d  = span_x_q;
          wy_d  = span_y_q;
          fs_d  = (span_x_q == '0) && (span_y_q == '0);
        end
        if (last_px) begin
          span_open_d = 1'b0;
          if (px_sel && open_eff) begin
            pend_d     = 1'b1;
            pend_val_d = new_val;
            pend_x_d   = new_x;
            pend_y_d   = cur_out_y;
          end else begin
            we_d  = 1'b1;
            pix_d = new_val;
            wx_d  = new_x;
            wy_d  = cur_out_y;
            fs_d  = (new_x == '0) && (cur_out_y == '0);
          end
        end else begin
          span_open_d = px_sel | open_eff;
          span_val_d  = new_val;
          span_x_d    = new_x;
          span_y_d    = cur_out_y;
        end
      end
`else
      if (px_sel && ln_sel) begin
        we_d  = 1'b1;
        pix_d = mono_pixel_in;
        wx_d  = cur_out_x;
        wy_d  = cur_out_y;
        fs_d  = (cur_out_x == '0) && (cur_out_y == '0);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StWaitSof;
      ex_q         <= '0;
      ey_q         <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      sync_error_q <= 1'b0;
      we_q         <= 1'b0;
      fs_q         <= 1'b0;
      pix_q        <= 1'b0;
      wx_q         <= '0;
      wy_q         <= '0;
`ifdef SCALER_OR_FILTER_EN
      span_open_q  <= 1'b0;
      span_val_q   <= 1'b0;
      span_x_q     <= '0;
      span_y_q     <= '0;
      pend_q       <= 1'b0;
      pend_val_q   <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      sync_error_q <= sync_error_d;
      we_q         <= we_d;
      fs_q         <= fs_d;
      pix_q        <= pix_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
`ifdef SCALER_OR_FILTER_EN
      span_open_q  <= span_open_d;
      span_val_q   <= span_val_d;
      span_x_q     <= span_x_d;
      span_y_q     <= span_y_d;
      pend_q       <= pend_d;
      pend_val_q   <= pend_val_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
`endif
    end
  end

  assign scaled_mono_pixel   = pix_q;
  assign scaled_write_enable = we_q;
  assign scaled_write_x      = wx_q;
  assign scaled_write_y      = wy_q;
  assign scaled_frame_start  = fs_q;
  assign sync_error          = sync_error_q;

endmodule

// File: tb/tb_scaler_dda.sv
// Directed bench for scaler_dda at 25x100 -> 16x57, which keeps the 25:16 horizontal step of
// 800 -> 512 and the 100:57 vertical step of 600 -> 342 at a fraction of the frame size.
module tb_scaler_dda;
  localparam int IW = 25;
  localparam int IH = 100;
  localparam int OW = 16;
  localparam int OH = 57;
  localparam int LastIdx = IW * IH - 1;

  logic       clk = 1'b0;
  logic       reset_n, enable_in, mono_pixel_in;
  logic [4:0] input_x;
  logic [6:0] input_y;
  logic       scaled_mono_pixel, scaled_write_enable, scaled_frame_start, sync_error;
  logic [3:0] scaled_write_x;
  logic [5:0] scaled_write_y;

  scaler_dda #(
    .INPUT_WIDTH  (IW),
    .INPUT_HEIGHT (IH),
    .OUTPUT_WIDTH (OW),
    .OUTPUT_HEIGHT(OH)
  ) u_dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable_in          (enable_in),
    .mono_pixel_in      (mono_pixel_in),
    .input_x            (input_x),
    .input_y            (input_y),
    .scaled_mono_pixel  (scaled_mono_pixel),
    .scaled_write_enable(scaled_write_enable),
    .scaled_write_x     (scaled_write_x),
    .scaled_write_y     (scaled_write_y),
    .scaled_frame_start (scaled_frame_start),
    .sync_error         (sync_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int p;
    int c;
  } wr_t;

  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  t_origin = 0;
  int  t_x2 = 0;
  int  clr_gen = 0;
  int  seen_gen = 0;
  wr_t wlog[$];
  wr_t base_log[$];
  int  cnt [OW][OH];
  int  val [OW][OH];
  int  fs_count, fs_bad, oob;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write is logged and tallied per output coordinate.
  always @(negedge clk) begin
    wr_t w;
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      wlog.delete();
      for (int j = 0; j < OW; j++) for (int k = 0; k < OH; k++) begin
        cnt[j][k] = 0;
        val[j][k] = 0;
      end
      fs_count = 0;
      fs_bad   = 0;
      oob      = 0;
    end
    if (scaled_write_enable) begin
      w.x = int'(scaled_write_x);
      w.y = int'(scaled_write_y);
      w.p = int'(scaled_mono_pixel);
      w.c = cyc;
      wlog.push_back(w);
      if (w.x < OW && w.y < OH) begin
        cnt[w.x][w.y]++;
        val[w.x][w.y] = w.p;
      end else begin
        oob++;
      end
    end
    if (scaled_frame_start) begin
      fs_count++;
      if (!(scaled_write_enable && scaled_write_x == 0 && scaled_write_y == 0)) fs_bad++;
    end
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic clr();
    clr_gen++;
  endtask

  task automatic px(input logic en, input int x, input int y, input logic p);
    enable_in     = en;
    input_x       = 5'(x);
    input_y       = 7'(y);
    mono_pixel_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) px(1'b0, 0, 0, 1'b0);
  endtask

  function automatic logic pat(input int mode, input int x, input int y);
    case (mode)
      0:       return x[0];
      1:       return (x == IW - 1) || (y == 2) || (y == IH - 1);
      default: return (x == 1) && (y == 0);
    endcase
  endfunction

  // Source pixel/row of output j/k: ceil(j*IW/OW), ceil(k*IH/OH).
  function automatic int xi(input int j);
    return (j * IW + OW - 1) / OW;
  endfunction

  function automatic int yi(input int k);
    return (k * IH + OH - 1) / OH;
  endfunction

  function automatic int exp_px(input int mode, input int j, input int k);
    int r;
    int e;
    r = 0;
`ifdef SCALER_OR_FILTER_EN
    e = (j == OW - 1) ? IW : xi(j + 1);
    for (int x = xi(j); x < e; x++) r = r | int'(pat(mode, x, yi(k)));
`else
    e = 0;
    r = int'(pat(mode, xi(j), yi(k))) + e;
`endif
    return r;
  endfunction

  task automatic drive_lin(input int mode, input int first, input int last, input int stall_at);
    int x;
    int y;
    for (int i = first; i <= last; i++) begin
      x = i % IW;
      y = i / IW;
      if (i == stall_at) repeat (5) px(1'b0, 0, 0, 1'b1);
      px(1'b1, x, y, pat(mode, x, y));
      if (i == 0) t_origin = cyc;
      if (i == 2) t_x2 = cyc;
    end
  endtask

  task automatic check_frame(input string tag, input int mode);
    int uniq_bad;
    int val_bad;
    uniq_bad = 0;
    val_bad  = 0;
    for (int j = 0; j < OW; j++) for (int k = 0; k < OH; k++) begin
      if (cnt[j][k] != 1) uniq_bad++;
      else if (val[j][k] != exp_px(mode, j, k)) val_bad++;
    end
    check_eq({tag, "_writes"}, wlog.size(), OW * OH);
    check_eq({tag, "_unique"}, uniq_bad, 0);
    check_eq({tag, "_values"}, val_bad, 0);
    check_eq({tag, "_oob"}, oob, 0);
    check_eq({tag, "_fs_count"}, fs_count, 1);
    check_eq({tag, "_fs_at_origin"}, fs_bad, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_we"}, int'(scaled_write_enable), 0);
    check_eq({tag, "_fs"}, int'(scaled_frame_start), 0);
    check_eq({tag, "_pix"}, int'(scaled_mono_pixel), 0);
    check_eq({tag, "_x"}, int'(scaled_write_x), 0);
    check_eq({tag, "_y"}, int'(scaled_write_y), 0);
    check_eq({tag, "_sync"}, int'(sync_error), 0);
  endtask

  function automatic int log_field(input int idx, input int f);
    if (idx >= wlog.size()) return -1;
    case (f)
      0:       return wlog[idx].x;
      1:       return wlog[idx].y;
      2:       return wlog[idx].p;
      default: return wlog[idx].c;
    endcase
  endfunction

  initial begin
    int first_pix[4];
    int diffs;
`ifdef SCALER_OR_FILTER_EN
    first_pix = '{1, 1, 0, 1};
`else
    first_pix = '{0, 0, 0, 1};
`endif
    reset_n = 1'b0;
    px(1'b1, 3, 2, 1'b1);
    px(1'b1, 0, 0, 1'b1);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    idle(2);

    // Full frame, pixel = x[0].
    clr();
    drive_lin(0, 0, LastIdx, -1);
    idle(3);
    check_frame("f1", 0);
`ifdef SCALER_OR_FILTER_EN
    check_eq("f1_first_latency", log_field(0, 3), t_x2);
`else
    check_eq("f1_first_latency", log_field(0, 3), t_origin);
`endif
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("line0_x%0d", i), log_field(i, 0), i);
      check_eq($sformatf("line0_pix%0d", i), log_field(i, 2), first_pix[i]);
    end
    check_eq("f1_sync", int'(sync_error), 0);
    base_log = wlog;

    // Same frame with a 5-cycle stall mid-line; write sequence must match.
    clr();
    drive_lin(0, 0, LastIdx, 3 * IW + 7);
    idle(3);
    check_eq("stall_writes", wlog.size(), base_log.size());
    diffs = 0;
    for (int i = 0; i < wlog.size() && i < base_log.size(); i++)
      if (wlog[i].x != base_log[i].x || wlog[i].y != base_log[i].y || wlog[i].p != base_log[i].p)
        diffs++;
    check_eq("stall_diffs", diffs, 0);

    // Edge pattern: last column, row 2, last row.
    clr();
    drive_lin(1, 0, LastIdx, -1);
    idle(3);
    check_frame("edges", 1);
    check_eq("x24_to_out15", val[15][0], 1);
    check_eq("x22_to_out14", val[14][0], 0);
    check_eq("row99_to_out56", val[0][56], 1);
    check_eq("row97_to_out55", val[0][55], 0);
    check_eq("row2_to_out1", val[0][1], 1);
    check_eq("row4_to_out2", val[0][2], 0);
    check_eq("row0_to_out0", val[0][0], 0);

    // Skip pixel (10,3): error, then silence until the next frame start.
    drive_lin(0, 0, 3 * IW + 9, -1);
    drive_lin(0, 3 * IW + 11, 3 * IW + 11, -1);
    clr();
    check_eq("skip_sync_set", int'(sync_error), 1);
    drive_lin(0, 3 * IW + 12, LastIdx, -1);
    idle(3);
    check_eq("skip_no_writes", wlog.size(), 0);
    check_eq("skip_sync_sticky", int'(sync_error), 1);
    clr();
    drive_lin(0, 0, 0, -1);
    check_eq("recover_sync_clear", int'(sync_error), 0);
    drive_lin(0, 1, LastIdx, -1);
    idle(3);
    check_frame("recover", 0);

    // Out-of-order (0,0) mid-frame restarts immediately but flags the error.
    drive_lin(0, 0, 100, -1);
    drive_lin(0, 0, 0, -1);
    clr();
    check_eq("restart_sync_set", int'(sync_error), 1);
    drive_lin(0, 1, LastIdx, -1);
    idle(3);
    check_frame("restart", 0);
    check_eq("restart_sync_kept", int'(sync_error), 1);

    // Reset mid-frame with the error flag set.
    drive_lin(0, 0, 12 * IW, -1);
    drive_lin(0, 5, 5, -1);
    reset_n = 1'b0;
    px(1'b1, 6, 0, 1'b1);
    check_outputs_zero("midrst");
    reset_n = 1'b1;
    clr();
    drive_lin(0, 12 * IW + 2, LastIdx, -1);
    idle(3);
    check_eq("midrst_no_writes", wlog.size(), 0);
    clr();
    drive_lin(0, 0, LastIdx, -1);
    idle(3);
    check_frame("after_rst", 0);

    // Single set pixel at (1,0).
    clr();
    drive_lin(2, 0, LastIdx, -1);
    idle(3);
`ifdef SCALER_OR_FILTER_EN
    check_eq("dot_out00", val[0][0], 1);
    check_eq("dot_cycle", log_field(0, 3), t_x2);
`else
    check_eq("dot_out00", val[0][0], 0);
    check_eq("dot_cycle", log_field(0, 3), t_origin);
`endif
    check_eq("dot_x", log_field(0, 0), 0);
    check_eq("dot_y", log_field(0, 1), 0);
    check_eq("dot_total", wlog.size(), OW * OH);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scaler_dda.md
Name: scaler_dda

Overview:
- Streaming monochrome downscaler with arbitrary rational ratio, using DDA/Bresenham accumulators instead of an integer scale factor. Handles 800x600 -> 512x342 correctly, emitting exactly OUTPUT_WIDTH x OUTPUT_HEIGHT writes per frame.
- Sits between the TFP401 capture/threshold stage and the frame-buffer write port, in the pixel-clock domain.
- Checks that input coordinates arrive in raster order and resynchronises on the next frame start when they do not.

Parameters:
- INPUT_WIDTH, 800, active input pixels per line.
- INPUT_HEIGHT, 600, active input lines per frame.
- OUTPUT_WIDTH, 512, output pixels per line. Must be <= INPUT_WIDTH; elaboration error otherwise.
- OUTPUT_HEIGHT, 342, output lines per frame. Must be <= INPUT_HEIGHT; elaboration error otherwise.

Ports:
- clk  in  1  pixel clock (tfp401_pclk).
- reset_n  in  1  synchronous, active-low reset.
- enable_in  in  1  input pixel valid.
- mono_pixel_in  in  1  input monochrome pixel.
- input_x  in  clog2(INPUT_WIDTH)  input X coordinate.
- input_y  in  clog2(INPUT_HEIGHT)  input Y coordinate.
- scaled_mono_pixel  out  1  output pixel value.
- scaled_write_enable  out  1  one-cycle write strobe.
- scaled_write_x  out  clog2(OUTPUT_WIDTH)  buffer X coordinate.
- scaled_write_y  out  clog2(OUTPUT_HEIGHT)  buffer Y coordinate.
- scaled_frame_start  out  1  pulses together with the write to (0,0).
- sync_error  out  1  sticky raster-order error flag; cleared at the next accepted frame start.

Behaviour:
- Reset (reset_n low at a clk edge) clears every output to 0, clears the accumulators and counters, and enters WAIT_SOF.
- Reset has priority over everything, including mid-frame. Any pending span is discarded.
- The state machine has two states.
  - WAIT_SOF: ignores pixels until enable_in is high with input_x==0 and input_y==0. That pixel is processed as the frame start and the block moves to ACTIVE.
  - ACTIVE: each valid pixel must equal the expected (ex, ey).
  - Expected coordinate advance: ex+1; after INPUT_WIDTH-1, ex wraps to 0 and ey increments.
  - Mismatch: set sync_error, suppress output for that pixel, return to WAIT_SOF.
  - A mismatching pixel that is itself (0,0) restarts the frame immediately in the same cycle and still sets sync_error.
  - After the pixel (INPUT_WIDTH-1, INPUT_HEIGHT-1), go to WAIT_SOF with no error.
- Horizontal DDA:
  - acc_x is reset to 0 at each line start (ex==0).
  - A pixel is selected when acc_x < OUTPUT_WIDTH.
  - After each pixel: acc_x += OUTPUT_WIDTH; if the result is >= INPUT_WIDTH, subtract INPUT_WIDTH.
  - Selected pixel i therefore maps to output j where i = ceil(j*INPUT_WIDTH/OUTPUT_WIDTH).
- Vertical DDA:
  - Same rule using acc_y and the line count.
  - acc_y is reset at frame start and updated after the last pixel of each line.
  - A line is selected when acc_y < OUTPUT_HEIGHT.
- Output counters:
  - out_x increments per selected pixel and is reset per line.
  - out_y increments per selected line and is reset per frame.
  - Neither may exceed OUTPUT_WIDTH-1 / OUTPUT_HEIGHT-1.
- Latency: a selected pixel on a selected line produces scaled_write_enable=1 on the next cycle, with registered pixel, x and y.
- scaled_write_enable is low in all other cycles. Coordinates and pixel hold their last value when not writing.
- enable_in low stalls: no state change and no write.
- Accumulator width is clog2(max(INPUT_WIDTH, INPUT_HEIGHT))+1 bits; no overflow for any legal parameters.

Optional Feature:
- Macro: SCALER_OR_FILTER_EN.
- Defined:
  - Horizontal output pixel = OR of all input pixels in its span (from the selected pixel up to, but not including, the next selected pixel, or end of line). This preserves 1-pixel black text lines.
  - The write for span j issues the cycle after the first pixel of span j+1, or the cycle after the line's last pixel.
  - Vertical selection is unchanged. Write count per frame is unchanged.
  - Reset or sync error discards the open span.
- Undefined: pure nearest neighbour as described above, 1-cycle latency.

Test Plan:
- Default params, full 800x600 raster with pixel = x[0] -> exactly 512*342 writes; each write's x/y is unique.
- Line 0 -> writes at x 0,1,2,3 come from input x 0,2,4,5 with pixels 0,0,0,1.
- Input x 799 maps to out x 511; input rows 0,2,4,599 map to out y 0,1,2,341.
- scaled_frame_start pulses once per frame, together with the write to (0,0).
- Skip pixel (10,3) -> sync_error=1 and no writes until the next (0,0).
- After the next (0,0): sync_error=0 and the frame completes normally.
- enable_in low for 5 cycles mid-line -> output identical to the unstalled run, apart from timing.
- reset_n low mid-frame -> all outputs are 0 next cycle; writes resume only after (0,0).
- With SCALER_OR_FILTER_EN, a single black pixel at input x=1, row 0 -> output (0,0) = 1, written in the cycle after input x=2.
- Without SCALER_OR_FILTER_EN, the same stimulus leaves output (0,0) = 0.
